// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: FSM state codes, header size and
// the loader address helper.
package boot_pkg;

  localparam int STATE_W   = 3;
  localparam int HDR_BYTES = 2;

  localparam logic [STATE_W-1:0] HDR_LO = 3'd0;
  localparam logic [STATE_W-1:0] HDR_HI = 3'd1;
  localparam logic [STATE_W-1:0] LOAD   = 3'd2;
  localparam logic [STATE_W-1:0] RUN    = 3'd3;
  localparam logic [STATE_W-1:0] ERR    = 3'd4;

  // Byte address of loader word idx; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [15:0] idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Packs a little-endian byte stream into 32-bit words. word_valid is asserted
// alongside the 4th byte; the first three bytes sit in a holding register.
module byte_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  lane;
  logic [23:0] hold;

  assign word_valid = rx_valid && (lane == 2'd3);
  assign word       = {rx_data, hold};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane <= 2'd0;
      hold <= 24'd0;
    end else if (clear) begin
      lane <= 2'd0;
      hold <= 24'd0;
    end else if (rx_valid) begin
      lane <= lane + 2'd1;
      case (lane)
        2'd0:    hold[7:0]   <= rx_data;
        2'd1:    hold[15:8]  <= rx_data;
        2'd2:    hold[23:16] <= rx_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/boot_mem_ctrl.sv
// Boot sequencer: loads a length-prefixed image from the UART into RAM while
// holding the CPU in reset, then releases the CPU and gives it the write port.
module boot_mem_ctrl
  import boot_pkg::*;
#(
  parameter logic [31:0] BOOT_BASE = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  input  logic        i_cpu_wr_valid,
  input  logic [31:0] i_cpu_wr_addr,
  input  logic [31:0] i_cpu_wr_data,
  output logic        o_cpu_reset,
  output logic        o_mem_wr_valid,
  output logic [31:0] o_mem_wr_addr,
  output logic [31:0] o_mem_wr_data,
  output logic [2:0]  o_state,
  output logic        o_err,
  output logic [15:0] o_words_loaded
);

  localparam int HDR_BITS = 8 * HDR_BYTES;

  logic [STATE_W-1:0]  state;
  logic [HDR_BITS-1:0] n_words;
  logic [15:0]         words_loaded;
  logic                ld_valid;
  logic [31:0]         ld_addr;
  logic [31:0]         ld_data;

  logic                pk_valid;
  logic [31:0]         pk_word;
  logic [HDR_BITS-1:0] hdr_n;

  assign hdr_n = {i_rx_data, n_words[7:0]};

  byte_word_packer u_packer (
    .clk        (clk),
    .rst        (i_reset),
    .clear      (state != LOAD),
    .rx_valid   (i_rx_valid && (state == LOAD)),
    .rx_data    (i_rx_data),
    .word       (pk_word),
    .word_valid (pk_valid)
  );

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= HDR_LO;
      n_words      <= '0;
      words_loaded <= 16'd0;
      ld_valid     <= 1'b0;
      ld_addr      <= 32'd0;
      ld_data      <= 32'd0;
    end else begin
      ld_valid <= 1'b0;
      case (state)
        HDR_LO: begin
          if (i_rx_valid) begin
            n_words[7:0] <= i_rx_data;
            state        <= HDR_HI;
          end
        end
        HDR_HI: begin
          if (i_rx_valid) begin
            n_words[15:8] <= i_rx_data;
            if (hdr_n == '0)
              state <= RUN;
            else if (32'(hdr_n) > MAX_WORDS)
              state <= ERR;
            else
              state <= LOAD;
          end
        end
        LOAD: begin
          if (pk_valid) begin
            ld_valid     <= 1'b1;
            ld_addr      <= word_addr(BOOT_BASE, words_loaded);
            ld_data      <= pk_word;
            words_loaded <= words_loaded + 16'd1;
          end
          // Leave LOAD on the edge after the final word's write pulse.
          if (ld_valid && (words_loaded == n_words))
            state <= RUN;
        end
        default: ;
      endcase
    end
  end

  // CPU owns the write port only once it is out of reset; before that its
  // requests are faults and are dropped.
  assign o_mem_wr_valid = (state == RUN) ? i_cpu_wr_valid : ld_valid;
  assign o_mem_wr_addr  = (state == RUN) ? i_cpu_wr_addr  : ld_addr;
  assign o_mem_wr_data  = (state == RUN) ? i_cpu_wr_data  : ld_data;

  assign o_cpu_reset    = (state != RUN);
  assign o_err          = (state == ERR);
  assign o_state        = state;
  assign o_words_loaded = words_loaded;

endmodule

// File: tb/tb_boot_mem_ctrl.sv
// Randomized scoreboard bench for boot_mem_ctrl: two instances (base 0 and
// base 0x1000) share stimulus; a negedge monitor pops expected writes.
module tb_boot_mem_ctrl;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_rx_valid;
  logic [7:0]  i_rx_data;
  logic        i_cpu_wr_valid;
  logic [31:0] i_cpu_wr_addr;
  logic [31:0] i_cpu_wr_data;

  logic        o0_cpu_reset, o1_cpu_reset;
  logic        o0_valid, o1_valid;
  logic [31:0] o0_addr, o1_addr, o0_data, o1_data;
  logic [2:0]  o0_state, o1_state;
  logic        o0_err, o1_err;
  logic [15:0] o0_words, o1_words;

  boot_mem_ctrl #(.BOOT_BASE(BASE0), .MAX_WORDS(1024)) dut0 (
    .clk(clk), .i_reset(i_reset), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .i_cpu_wr_valid(i_cpu_wr_valid), .i_cpu_wr_addr(i_cpu_wr_addr),
    .i_cpu_wr_data(i_cpu_wr_data), .o_cpu_reset(o0_cpu_reset),
    .o_mem_wr_valid(o0_valid), .o_mem_wr_addr(o0_addr), .o_mem_wr_data(o0_data),
    .o_state(o0_state), .o_err(o0_err), .o_words_loaded(o0_words));

  boot_mem_ctrl #(.BOOT_BASE(BASE1), .MAX_WORDS(1024)) dut1 (
    .clk(clk), .i_reset(i_reset), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .i_cpu_wr_valid(i_cpu_wr_valid), .i_cpu_wr_addr(i_cpu_wr_addr),
    .i_cpu_wr_data(i_cpu_wr_data), .o_cpu_reset(o1_cpu_reset),
    .o_mem_wr_valid(o1_valid), .o_mem_wr_addr(o1_addr), .o_mem_wr_data(o1_data),
    .o_state(o1_state), .o_err(o1_err), .o_words_loaded(o1_words));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        q0[$];
  wr_t        q1[$];
  wr_t        e0, e1;
  logic [7:0] img[$];
  bit         noise;
  int         total = 0;
  int         bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (o0_valid !== 1'b0) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL dut0_unexpected_write: got addr=0x%08h data=0x%08h want none", o0_addr, o0_data);
      end else begin
        e0 = q0.pop_front();
        check("dut0_wr_addr", o0_addr, e0.addr);
        check("dut0_wr_data", o0_data, e0.data);
      end
    end
    if (o1_valid !== 1'b0) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1_unexpected_write: got addr=0x%08h data=0x%08h want none", o1_addr, o1_data);
      end else begin
        e1 = q1.pop_front();
        check("dut1_wr_addr", o1_addr, e1.addr);
        check("dut1_wr_data", o1_data, e1.data);
      end
    end
  end

  task automatic status(input logic [2:0] st, input logic cr, input logic er, input logic [15:0] wl);
    check("dut0_state", o0_state, st);      check("dut1_state", o1_state, st);
    check("dut0_cpu_reset", o0_cpu_reset, cr); check("dut1_cpu_reset", o1_cpu_reset, cr);
    check("dut0_err", o0_err, er);          check("dut1_err", o1_err, er);
    check("dut0_words", o0_words, wl);      check("dut1_words", o1_words, wl);
  endtask

  task automatic reset_vals();
    status(3'd0, 1'b1, 1'b0, 16'd0);
    check("dut0_rst_valid", o0_valid, 0); check("dut1_rst_valid", o1_valid, 0);
    check("dut0_rst_addr", o0_addr, 0);   check("dut1_rst_addr", o1_addr, 0);
    check("dut0_rst_data", o0_data, 0);   check("dut1_rst_data", o1_data, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    i_reset = 1'b1;
    #1 reset_vals();
    @(posedge clk); #3;
    i_reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // One rx strobe; gap = idle cycles afterwards. With noise set, a CPU write
  // to 0x40 may ride along; outside RUN it must never reach the RAM port.
  task automatic rx_byte(input logic [7:0] b, input int gap);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    if (noise && $urandom_range(0, 2) == 0) begin
      i_cpu_wr_valid = 1'b1;
      i_cpu_wr_addr  = 32'h40;
      i_cpu_wr_data  = $urandom;
    end
    @(posedge clk); #1;
    i_rx_valid     = 1'b0;
    i_cpu_wr_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push_word(input int idx, input logic [31:0] w);
    q0.push_back('{BASE0 + 32'(idx) * 32'd4, w});
    q1.push_back('{BASE1 + 32'(idx) * 32'd4, w});
  endtask

  // Sends header + img, expecting word i = img[4i] | img[4i+1]<<8 | ...
  task automatic load_img(input int gapmax);
    logic [15:0] nn;
    logic [31:0] w;
    int          n;
    n  = img.size() / 4;
    nn = 16'(n);
    rx_byte(nn[7:0], $urandom_range(0, gapmax));
    rx_byte(nn[15:8], $urandom_range(0, gapmax));
    for (int i = 0; i < n; i++) begin
      w = 32'(img[4*i]) + (32'(img[4*i+1]) << 8) + (32'(img[4*i+2]) << 16) + (32'(img[4*i+3]) << 24);
      for (int k = 0; k < 4; k++) begin
        if (k == 3) push_word(i, w);
        if (i == n - 1 && k == 3) rx_byte(img[4*i+k], 0);
        else rx_byte(img[4*i+k], $urandom_range(0, gapmax));
      end
    end
    // Final write pulse is on the port now; CPU still held.
    status(3'd2, 1'b1, 1'b0, nn);
    @(posedge clk); #1;
    status(3'd3, 1'b0, 1'b0, nn);
  endtask

  task automatic rand_img(input int n);
    img.delete();
    for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input bit expect_it);
    i_cpu_wr_valid = 1'b1;
    i_cpu_wr_addr  = a;
    i_cpu_wr_data  = d;
    if (expect_it) begin
      q0.push_back('{a, d});
      q1.push_back('{a, d});
    end
    @(posedge clk); #1;
    i_cpu_wr_valid = 1'b0;
  endtask

  task automatic run_phase(input logic [15:0] wl);
    for (int i = 0; i < 3; i++) begin
      cpu_write($urandom, $urandom, 1'b1);
      rx_byte(8'($urandom), $urandom_range(0, 1));
    end
    status(3'd3, 1'b0, 1'b0, wl);
  endtask

  initial begin
    i_reset = 1'b1; i_rx_valid = 1'b0; i_rx_data = 8'd0;
    i_cpu_wr_valid = 1'b0; i_cpu_wr_addr = 32'd0; i_cpu_wr_data = 32'd0;
    noise = 1'b0;
    #3 reset_vals();
    @(posedge clk); #3;
    i_reset = 1'b0;
    @(posedge clk); #1;

    // Directed two-word image.
    img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    load_img(1);
    run_phase(16'd2);

    // Empty image: straight to RUN, zero-latency CPU pass-through.
    do_reset();
    rx_byte(8'h00, 1);
    rx_byte(8'h00, 0);
    status(3'd3, 1'b0, 1'b0, 16'd0);
    i_cpu_wr_valid = 1'b1; i_cpu_wr_addr = 32'h100; i_cpu_wr_data = 32'hDEADBEEF;
    q0.push_back('{32'h100, 32'hDEADBEEF});
    q1.push_back('{32'h100, 32'hDEADBEEF});
    #1;
    check("dut0_pass_valid", o0_valid, 1);
    check("dut0_pass_addr", o0_addr, 32'h100);
    check("dut1_pass_data", o1_data, 32'hDEADBEEF);
    @(posedge clk); #1;
    i_cpu_wr_valid = 1'b0;

    // N = 1025 exceeds the limit: ERR, everything ignored.
    do_reset();
    rx_byte(8'h01, 0);
    rx_byte(8'h04, 1);
    status(3'd4, 1'b1, 1'b1, 16'd0);
    noise = 1'b1;
    for (int i = 0; i < 8; i++) rx_byte(8'($urandom), $urandom_range(0, 1));
    cpu_write(32'h200, 32'h12345678, 1'b0);
    noise = 1'b0;
    status(3'd4, 1'b1, 1'b1, 16'd0);

    // N = 3 aborted by asynchronous reset after the 5th data byte.
    do_reset();
    noise = 1'b1;
    rand_img(3);
    rx_byte(8'h03, 1);
    rx_byte(8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 3)
        push_word(0, 32'(img[0]) + (32'(img[1]) << 8) + (32'(img[2]) << 16) + (32'(img[3]) << 24));
      rx_byte(img[i], $urandom_range(0, 1));
    end
    #2 i_reset = 1'b1;
    #1 reset_vals();
    #2 i_reset = 1'b0;
    @(posedge clk); #1;
    rand_img(1);
    load_img(1);
    noise = 1'b0;
    run_phase(16'd1);

    // Back-to-back strobes, then the largest accepted image.
    do_reset();
    rand_img(2);
    load_img(0);
    do_reset();
    rand_img(1024);
    load_img(0);
    run_phase(16'd1024);

    // Random images with random gaps and stray CPU writes during load.
    for (int t = 0; t < 5; t++) begin
      do_reset();
      noise = 1'b1;
      rand_img($urandom_range(1, 24));
      load_img(2);
      noise = 1'b0;
      run_phase(16'(img.size() / 4));
    end

    repeat (3) @(posedge clk);
    #1;
    check("dut0_pending_writes", 32'(q0.size()), 32'd0);
    check("dut1_pending_writes", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/boot_mem_ctrl.md
Name: boot_mem_ctrl

Overview:
Boot sequencer and RAM write-port arbiter for the CPU test system. After reset it holds the CPU in reset. It then receives a length-prefixed program image over the UART receive byte stream and packs the bytes into 32-bit words. It writes those words into RAM, then releases the CPU and hands the RAM write port over to it. It sits between rx_uart, cpu and ram, replacing the direct byte path from the receiver into RAM.

Parameters:
BOOT_BASE, 32'h0000_0000, RAM byte address of the first loaded word.
MAX_WORDS, 1024, largest accepted image in 32-bit words.

Ports:
clk  input  1  system clock.
i_reset  input  1  asynchronous, active-high reset.
i_rx_valid  input  1  one-cycle strobe: received byte is valid.
i_rx_data  input  8  received byte.
i_cpu_wr_valid  input  1  CPU write request.
i_cpu_wr_addr  input  32  CPU write byte address.
i_cpu_wr_data  input  32  CPU write data.
o_cpu_reset  output  1  active-high reset to the CPU.
o_mem_wr_valid  output  1  RAM write strobe.
o_mem_wr_addr  output  32  RAM write byte address.
o_mem_wr_data  output  32  RAM write data.
o_state  output  3  current FSM state encoding.
o_err  output  1  sticky error flag: image too large.
o_words_loaded  output  16  count of words written by the loader.

Behaviour:
- Clock and reset: one clock, clk; i_reset is asynchronous and active-high.
- Reset values: o_cpu_reset=1, o_mem_wr_valid=0, o_mem_wr_addr=0, o_mem_wr_data=0, o_err=0, o_words_loaded=0, state=HDR_LO. The byte lane index and the word assembler clear to 0.
- States:
  - HDR_LO=0, HDR_HI=1, LOAD=2, RUN=3, ERR=4.
  - HDR_LO: on i_rx_valid, latch N[7:0] and go to HDR_HI.
  - HDR_HI: on i_rx_valid, latch N[15:8]. If N==0, go to RUN. If N>MAX_WORDS, go to ERR. Otherwise go to LOAD.
  - LOAD:
    - Bytes are little-endian. The first byte goes to [7:0], the fourth to [31:24].
    - On the 4th byte, the next cycle shows o_mem_wr_valid=1 for exactly one cycle, with addr = BOOT_BASE + 4*o_words_loaded and data = the assembled word.
    - o_words_loaded increments in that same cycle.
    - The byte lane index wraps 3->0.
    - When the write of word N-1 is issued, the state goes to RUN on the following edge.
  - RUN: o_cpu_reset=0 from the first RUN cycle onward, so it deasserts one cycle after the last loader write pulse.
  - ERR: o_err=1 and o_cpu_reset stays 1. All rx bytes are ignored. Only i_reset exits this state.
- Write-port arbitration:
  - In any state other than RUN, the CPU write inputs are ignored. The CPU is held in reset, so a write request is a fault, and it is dropped.
  - In RUN, o_mem_wr_* is a combinational pass-through of i_cpu_wr_* with zero latency.
  - In RUN, i_rx_valid is ignored; no further loading happens.
- Loader write outputs are registered. o_mem_wr_addr and o_mem_wr_data hold their last value when o_mem_wr_valid=0.
- Width rules:
  - N is 16 bits.
  - The address is computed as BOOT_BASE + {o_words_loaded,2'b00}, zero-extended to 32 bits, wrapping modulo 2^32.
- Simultaneous events: an rx byte arriving in the same cycle as a loader write pulse is accepted normally. The assembler uses a separate holding register, so back-to-back strobes lose no bytes.
- Reset mid-operation: an asynchronous reset during LOAD aborts the load. It returns to HDR_LO, asserts o_cpu_reset immediately, and drops any pending write pulse. Words already written remain in RAM.

Decomposition:
- Shared package boot_pkg holds the state enum (HDR_LO..ERR), the state width constant (3), and the header length constant (2 bytes).
- One natural sub-module: byte_word_packer. It takes the rx strobe and byte, keeps the lane counter, and emits a 32-bit word plus a one-cycle word_valid; it has a clear input. The FSM, counters and arbitration mux live in boot_mem_ctrl.

Test Plan:
1. Reset, then bytes 02 00 | 11 22 33 44 | 55 66 77 88 -> two write pulses, (addr 0x0, data 0x44332211) and (addr 0x4, data 0x88776655). o_words_loaded=2. o_cpu_reset falls one cycle after the 2nd pulse. o_state=RUN.
2. Header 00 00 -> RUN directly with no write pulses. o_cpu_reset=0. A following CPU write (addr 0x100, data 0xDEADBEEF, valid=1) appears on o_mem_wr_* in the same cycle.
3. Header 01 04 (N=1025) with MAX_WORDS=1024 -> ERR, o_err=1, o_cpu_reset stays 1. Further rx bytes and CPU writes produce no o_mem_wr_valid.
4. During LOAD, assert i_cpu_wr_valid=1 with addr 0x40 -> no write on o_mem_wr_*; only loader pulses appear.
5. N=3; after the 5th data byte, pulse i_reset asynchronously mid-cycle -> o_cpu_reset=1 immediately, state=HDR_LO, o_words_loaded=0. A fresh header 01 00 plus 4 bytes loads correctly to addr 0x0.
6. Back-to-back rx strobes on consecutive cycles for N=2 with BOOT_BASE=0x1000 -> writes to 0x1000 and 0x1004 with correct data and no dropped bytes.
